// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment display drivers.
// Holds the hex lookup patterns, the blank pattern and the scan state type.
package seg7_scan_driver_pkg;

    // All segments off. Segments are active-low.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    // Entry 15 is listed first because the array is packed.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        return HEX_SEG[v];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Ports: hex (4-bit value) -> seg (7-bit {g,f,e,d,c,b,a}, active-low).
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_seg(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with double-buffered data.
// Ports: clk, rst (async high); wr/wdata/wdp/wen write staging;
//        an/seg/dp active-low display drive; frame_start, pending status.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SHOW_CYC  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [31:0]       wdata,
    input  logic [DIGITS-1:0] wdp,
    input  logic [DIGITS-1:0] wen,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame_start,
    output logic              pending
);

    localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_t       state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;

    // Staging is written by the CPU side at any time.
    logic [31:0]       stg_data;
    logic [DIGITS-1:0] stg_dp;
    logic [DIGITS-1:0] stg_en;

    // Shadow is what the scanner displays; it only changes at frame wrap.
    logic [31:0]       shd_data;
    logic [DIGITS-1:0] shd_dp;
    logic [DIGITS-1:0] shd_en;

    logic [3:0]        nib;
    logic [6:0]        dec_seg;
    logic              en_cur;
    logic              dp_cur;
    logic [DIGITS-1:0] an_show;

    logic              blank_done;
    logic              show_done;
    logic              wrap;

    assign nib    = shd_data[{idx, 2'b00} +: 4];
    assign en_cur = shd_en[idx];
    assign dp_cur = shd_dp[idx];

    seg7_hex_decode u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // A disabled digit keeps its anode off for the whole slot.
    always_comb begin
        an_show      = '1;
        an_show[idx] = ~en_cur;
    end

    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    assign show_done  = (state == SHOW)  && (cnt == SHOW_LAST);
    assign wrap       = show_done && (idx == IDX_LAST);

    // Scan FSM. Display outputs are loaded on the same edge as the
    // state change so they never lag the slot they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            unique case (state)
                BLANK: begin
                    if (blank_done) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= an_show;
                        seg   <= en_cur ? dec_seg : SEG_OFF;
                        dp    <= ~(dp_cur & en_cur);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        an    <= '1;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Double buffer. A write on the commit edge lands in staging after
    // the shadow has taken the old staging, so it waits one more frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_data <= '0;
            stg_dp   <= '0;
            stg_en   <= '0;
            shd_data <= '0;
            shd_dp   <= '0;
            shd_en   <= '0;
            pending  <= 1'b0;
        end else begin
            if (wrap && pending) begin
                shd_data <= stg_data;
                shd_dp   <= stg_dp;
                shd_en   <= stg_en;
            end
            if (wr) begin
                stg_data <= wdata;
                stg_dp   <= wdp;
                stg_en   <= wen;
                pending  <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (8 digits, 4 show, 2 blank).
// Table-driven digit checks plus hand sequences for buffering and reset.
module tb_seg7_scan_driver;

    localparam int DIGITS = 8;
    localparam int SLOT   = 6;
    localparam int FRAME  = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [7:0]  wdp = '0;
    logic [7:0]  wen = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SHOW_CYC  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .wdata       (wdata),
        .wdp         (wdp),
        .wen         (wen),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start),
        .pending     (pending)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 60);
        chk("frame_start_seen", {31'b0, frame_start}, 32'd1);
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] e,
                         input logic [7:0] p);
        wr    = 1'b1;
        wdata = d;
        wen   = e;
        wdp   = p;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Continuous invariants.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("an_onehot", {31'b0, ($countones(~an) <= 1)}, 32'd1);
            if (frame_start === 1'b1)
                chk("an_dark_at_frame", {24'b0, an}, 32'hFF);
        end
    end

    typedef struct {
        logic [31:0] d;
        logic [7:0]  e;
        logic [7:0]  p;
        int          dig;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vt[17];

    initial begin
        int lit;
        int o;
        logic [7:0] ea;

        vt[0]  = '{32'h1234ABCD, 8'hFF, 8'h01, 0, 8'hFE, 7'h21, 1'b0};
        vt[1]  = '{32'h1234ABCD, 8'hFF, 8'h01, 7, 8'h7F, 7'h79, 1'b1};
        vt[2]  = '{32'h1234ABCD, 8'hFF, 8'h01, 3, 8'hF7, 7'h08, 1'b1};
        vt[3]  = '{32'h1234ABCD, 8'hFF, 8'h01, 4, 8'hEF, 7'h19, 1'b1};
        vt[4]  = '{32'h88888888, 8'hF7, 8'h00, 3, 8'hFF, 7'h7F, 1'b1};
        vt[5]  = '{32'h88888888, 8'hF7, 8'h00, 2, 8'hFB, 7'h00, 1'b1};
        vt[6]  = '{32'h88888888, 8'hF7, 8'hFF, 3, 8'hFF, 7'h7F, 1'b1};
        vt[7]  = '{32'h88888888, 8'hF7, 8'hFF, 4, 8'hEF, 7'h00, 1'b0};
        vt[8]  = '{32'h76543210, 8'hFF, 8'h20, 5, 8'hDF, 7'h12, 1'b0};
        vt[9]  = '{32'hFEDCBA98, 8'hFF, 8'h00, 6, 8'hBF, 7'h06, 1'b1};
        vt[10] = '{32'hFEDCBA98, 8'hFF, 8'h00, 1, 8'hFD, 7'h10, 1'b1};
        vt[11] = '{32'h00000C0B, 8'h07, 8'h00, 0, 8'hFE, 7'h03, 1'b1};
        vt[12] = '{32'h00000C0B, 8'h07, 8'h00, 1, 8'hFD, 7'h40, 1'b1};
        vt[13] = '{32'h00000C0B, 8'h07, 8'h04, 2, 8'hFB, 7'h46, 1'b0};
        vt[14] = '{32'h00000C0B, 8'h07, 8'h00, 3, 8'hFF, 7'h7F, 1'b1};
        vt[15] = '{32'h00000006, 8'h01, 8'h01, 0, 8'hFE, 7'h02, 1'b0};
        vt[16] = '{32'h00000070, 8'h02, 8'h00, 1, 8'hFD, 7'h78, 1'b1};

        // Reset release with no write: dark, frame_start every 48.
        step(2);
        rst = 1'b0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step(1);
            chk("rst_dark_an", {24'b0, an}, 32'hFF);
            chk("rst_dark_seg", {25'b0, seg}, 32'h7F);
            chk("rst_fs", {31'b0, frame_start},
                {31'b0, (k == FRAME || k == 2 * FRAME)});
        end
        chk("rst_pending", {31'b0, pending}, 32'd0);

        // Full-frame slot timing with all digits enabled.
        wait_frame();
        write(32'h1234ABCD, 8'hFF, 8'h01);
        wait_frame();
        for (int off = 0; off < FRAME; off++) begin
            ea = (off % SLOT < 2) ? 8'hFF : ~(8'h01 << (off / SLOT));
            chk("slot_an", {24'b0, an}, {24'b0, ea});
            step(1);
        end

        // Table-driven digit checks.
        for (int i = 0; i < 17; i++) begin
            wait_frame();
            write(vt[i].d, vt[i].e, vt[i].p);
            chk("vec_pend_set", {31'b0, pending}, 32'd1);
            wait_frame();
            chk("vec_pend_clr", {31'b0, pending}, 32'd0);
            o = vt[i].dig * SLOT + 1;
            step(o);
            chk("vec_pre_dark", {24'b0, an}, 32'hFF);
            for (int r = 0; r < 2; r++) begin
                step(r == 0 ? 1 : 3);
                chk("vec_an", {24'b0, an}, {24'b0, vt[i].an});
                chk("vec_seg", {25'b0, seg}, {25'b0, vt[i].seg});
                chk("vec_dp", {31'b0, dp}, {31'b0, vt[i].dp});
            end
            step(1);
            chk("vec_post_dark", {24'b0, an}, 32'hFF);
        end

        // Write coincident with the commit edge is deferred a frame.
        wait_frame();
        write(32'h11111111, 8'hFF, 8'h00);
        step(46);
        wr    = 1'b1;
        wdata = 32'h22222222;
        wen   = 8'hFF;
        wdp   = 8'h00;
        step(1);
        wr = 1'b0;
        chk("coin_fs", {31'b0, frame_start}, 32'd1);
        chk("coin_pend", {31'b0, pending}, 32'd1);
        step(2);
        chk("coin_old_an", {24'b0, an}, 32'hFE);
        chk("coin_old_seg", {25'b0, seg}, 32'h79);
        chk("coin_pend_hold", {31'b0, pending}, 32'd1);
        wait_frame();
        chk("coin_pend_clr", {31'b0, pending}, 32'd0);
        step(2);
        chk("coin_new_seg", {25'b0, seg}, 32'h24);

        // Two writes in one frame: only the last is ever shown.
        wait_frame();
        write(32'h00000000, 8'hFF, 8'h00);
        write(32'hFFFFFFFF, 8'hFF, 8'h00);
        wait_frame();
        lit = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (an !== 8'hFF) begin
                lit++;
                chk("last_wins_seg", {25'b0, seg}, 32'h0E);
            end
            step(1);
        end
        chk("last_wins_lit", lit, 32);

        // Reset during digit 5 show slot with data staged.
        wait_frame();
        write(32'h12345678, 8'hFF, 8'hFF);
        step(31);
        chk("mid_an_d5", {24'b0, an}, 32'hDF);
        chk("mid_pend", {31'b0, pending}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an", {24'b0, an}, 32'hFF);
        chk("mid_rst_seg", {25'b0, seg}, 32'h7F);
        chk("mid_rst_dp", {31'b0, dp}, 32'd1);
        chk("mid_rst_pend", {31'b0, pending}, 32'd0);
        chk("mid_rst_fs", {31'b0, frame_start}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            step(1);
            chk("post_rst_an", {24'b0, an}, 32'hFF);
            chk("post_rst_fs", {31'b0, frame_start},
                {31'b0, (k == FRAME)});
        end
        chk("post_rst_pend", {31'b0, pending}, 32'd0);
        for (int k = 0; k < FRAME; k++) begin
            step(1);
            chk("post_rst_dark2", {24'b0, an}, 32'hFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side board conditioner for the RV32 CPU FPGA top; the counterpart of the input debounce filter.
- Drives a multiplexed, common-anode 8-digit seven-segment display from a 32-bit value written by the CPU/MMIO side.
- Time-multiplexes digits with a blanking gap between slots to suppress ghosting.
- Double-buffers the displayed value so updates apply only at frame boundaries, with no tearing.

Parameters:
- DIGITS, 8, number of digits; each digit shows one nibble of the data word; 1..8.
- SHOW_CYC, 100000, clk cycles a digit is lit per slot; >=1.
- BLANK_CYC, 1000, clk cycles with all anodes off before each lit slot; >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wr  in  1  one-cycle write strobe; captures wdata, wdp and wen into staging.
- wdata  in  32  hex value; nibble i drives digit i (digit 0 = rightmost).
- wdp  in  DIGITS  decimal-point enables; bit i lights the dp of digit i.
- wen  in  DIGITS  digit enables; 0 keeps that digit dark for its whole slot.
- an  out  DIGITS  anode selects, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit index wraps to 0 (new frame).
- pending  out  1  staged data not yet committed to display.

Behaviour:
- Reset (async, immediate):
  - an = all 1, seg = 7'h7F, dp = 1, frame_start = 0, pending = 0.
  - Staging and shadow registers = 0; wen_shadow = 0, so the display stays dark after reset.
  - idx = 0, state = BLANK, cnt = 0.
- Outputs are registered. an/seg/dp change on the same clk edge as the state/idx change; no combinational path from inputs to outputs.
- FSM, two states:
  - BLANK: an = all 1, seg = 7'h7F, dp = 1.
    - cnt counts 0..BLANK_CYC-1.
    - At terminal count: go to SHOW, cnt = 0.
  - SHOW:
    - an[idx] = ~wen_shadow[idx]; all other an bits = 1.
    - seg = hexdec(shadow[4*idx+3:4*idx]) if wen_shadow[idx], else 7'h7F.
    - dp = ~(wdp_shadow[idx] & wen_shadow[idx]).
    - cnt counts 0..SHOW_CYC-1.
    - At terminal count: go to BLANK, cnt = 0, idx = (idx == DIGITS-1) ? 0 : idx+1.
- Slot length = BLANK_CYC + SHOW_CYC. Frame length = DIGITS × slot length.
- Commit: on the SHOW→BLANK edge where idx wraps from DIGITS-1 to 0:
  - frame_start = 1 for that one cycle.
  - If pending: shadow registers <= staging registers and pending <= 0.
- Write: wr = 1 loads the staging registers and sets pending = 1 on the next edge.
- Write in the same cycle as commit:
  - Commit uses the staging content from before this edge.
  - Staging takes the new data and pending stays 1, so the new data applies next frame.
- Multiple writes within one frame: the last one wins. Intermediate values are never displayed.
- Nibbles above DIGITS-1 are ignored.
- hexdec, active-low {g..a}:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011, C → 1000110, d → 0100001, E → 0000110, F → 0001110.
- Invariant: at most one an bit is 0 in any cycle. All an bits are 1 throughout every BLANK state.
- Counter widths: cnt width = clog2(max(SHOW_CYC, BLANK_CYC)); idx width = clog2(DIGITS), minimum 1.
- Reset mid-frame: outputs go dark immediately and scanning restarts from BLANK, idx 0. Staged data and the pending flag are discarded.

Decomposition:
- Shared board package holds:
  - the HEX_SEG lookup constants (16 × 7-bit active-low patterns);
  - SEG_OFF = 7'h7F;
  - the scan state enum {BLANK, SHOW}.
- One sub-module, seg7_hex_decode: combinational 4-bit → 7-bit active-low. It is reused by other debug displays.
- The FSM, counters, staging and shadow registers stay in seg7_scan_driver.

Test Plan:
- Use DIGITS = 8, SHOW_CYC = 4, BLANK_CYC = 2 for all scenarios.
- Reset release with no write:
  - Check: an = 8'hFF and seg = 7'h7F for a whole frame (48 cycles).
  - Check: frame_start pulses every 48 cycles.
- wr with wdata = 32'h1234ABCD, wen = 8'hFF, wdp = 8'h01 mid-frame:
  - pending = 1 until the next frame_start.
  - Next frame, digit 0 slot: an = 8'hFE, seg = 0100001 ('d'), dp = 0.
  - Digit 7 slot: an = 8'h7F, seg = 1111001 ('1'), dp = 1.
- Slot timing: each digit shows exactly 4 cycles preceded by exactly 2 all-dark cycles.
  - Assert an has at most one zero bit every cycle.
- wen = 8'b11110111 with wdata = 32'h88888888: the digit 3 slot keeps an = 8'hFF and seg = 7'h7F, and the other digits show 0000000.
- Two writes in one frame (32'h00000000 then 32'hFFFFFFFF): only F (0001110) is ever displayed.
  - A wr coincident with frame_start defers its data by one full frame with pending = 1 held.
- rst asserted during the SHOW slot of digit 5: outputs go dark the same cycle.
  - After release: no digit lights; scan restarts at idx 0 after 2 blank cycles, with pending = 0.
